// File: rtl/rv_pkg.sv
//------------------------------------------------------------------------------
// rv_pkg : shared types and helpers for the rv_pipeline skid-buffer chain
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // Width of a counter that spans 0..2*depth words.
    function automatic int occ_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv_stage.sv
//------------------------------------------------------------------------------
// rv_stage : one ready/valid skid stage, all outputs decoded from registers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv_stage
    import rv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    stage_state_t     r_state;
    stage_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;

    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state != EMPTY);
    assign out_data   = r_main;
    assign w_in_fire  = in_valid && (r_state != FULL);
    assign w_out_fire = out_ready && (r_state != EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = BUSY;
                    w_load_main = 1'b1;
                end
            end
            BUSY: begin
                case ({w_in_fire, w_out_fire})
                    2'b10: begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end
                    2'b01:   w_state_nxt = EMPTY;
                    2'b11:   w_load_main = 1'b1;
                    default: w_state_nxt = BUSY;
                endcase
            end
            FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = BUSY;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rv_pipeline.sv
//------------------------------------------------------------------------------
// rv_pipeline : DEPTH-stage registered ready/valid pipeline (timing breaker)
// Optional stats ports (occupancy, xfer_count) under RV_PIPELINE_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv_pipeline
    import rv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            us_data,
    input  logic                        us_valid,
    output logic                        us_ready,
    output logic [WIDTH-1:0]            ds_data,
    output logic                        ds_valid,
    input  logic                        ds_ready
`ifdef RV_PIPELINE_STATS_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy,
    output logic [31:0]                 xfer_count
`endif
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("rv_pipeline: DEPTH must be at least 1");
    end

    // Index k is the link feeding stage k; index DEPTH is the downstream port.
    logic [WIDTH-1:0] w_data  [0:DEPTH];
    logic             w_valid [0:DEPTH];
    logic             w_ready [0:DEPTH];

    assign w_data[0]      = us_data;
    assign w_valid[0]     = us_valid;
    assign us_ready       = w_ready[0];
    assign ds_data        = w_data[DEPTH];
    assign ds_valid       = w_valid[DEPTH];
    assign w_ready[DEPTH] = ds_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        rv_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (w_data[k]),
            .in_valid (w_valid[k]),
            .in_ready (w_ready[k]),
            .out_data (w_data[k+1]),
            .out_valid(w_valid[k+1]),
            .out_ready(w_ready[k+1])
        );
    end

`ifdef RV_PIPELINE_STATS_EN
    localparam int c_OCC_W = occ_width(DEPTH);

    logic               w_us_fire;
    logic               w_ds_fire;
    logic [c_OCC_W-1:0] r_occupancy;
    logic [31:0]        r_xfer_count;

    assign w_us_fire  = us_valid && us_ready;
    assign w_ds_fire  = ds_valid && ds_ready;
    assign occupancy  = r_occupancy;
    assign xfer_count = r_xfer_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occupancy  <= '0;
            r_xfer_count <= '0;
        end else begin
            case ({w_us_fire, w_ds_fire})
                2'b10:   r_occupancy <= r_occupancy + c_OCC_W'(1);
                2'b01:   r_occupancy <= r_occupancy - c_OCC_W'(1);
                default: r_occupancy <= r_occupancy;
            endcase
            if (w_ds_fire) begin
                r_xfer_count <= r_xfer_count + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_pipeline.sv
// tb_rv_pipeline : scoreboard bench driving DEPTH=1,2,5 instances with shared stimulus;
// directed checks target the DEPTH=2 instance (g_dut[1]).
`default_nettype none

module tb_rv_pipeline;

    localparam int WIDTH = 16;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b1;
    logic [WIDTH-1:0] us_data  = '0;
    logic             us_valid = 1'b0;
    logic             ds_ready = 1'b0;

    logic             us_ready_a [3];
    logic             ds_valid_a [3];
    logic [WIDTH-1:0] ds_data_a  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : 5;
`ifdef RV_PIPELINE_STATS_EN
        logic [$clog2(2*D+1)-1:0] occupancy;
        logic [31:0]              xfer_count;
`endif
        rv_pipeline #(
            .WIDTH(WIDTH),
            .DEPTH(D)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .us_data   (us_data),
            .us_valid  (us_valid),
            .us_ready  (us_ready_a[g]),
            .ds_data   (ds_data_a[g]),
            .ds_valid  (ds_valid_a[g]),
            .ds_ready  (ds_ready)
`ifdef RV_PIPELINE_STATS_EN
            ,
            .occupancy (occupancy),
            .xfer_count(xfer_count)
`endif
        );

        logic [WIDTH-1:0] q [$];
        logic             hold      = 1'b0;
        logic [WIDTH-1:0] hold_data = '0;
        logic [WIDTH-1:0] exp_word;

        // Inputs change just after posedge, so negedge values equal the next edge's.
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk($sformatf("hold_valid_d%0d", D), 32'(ds_valid_a[g]), 32'd1);
                    chk($sformatf("hold_data_d%0d", D), 32'(ds_data_a[g]), 32'(hold_data));
                end
                if (ds_valid_a[g] && ds_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sb_spurious_d%0d", D), 32'(q.size()), 32'd1);
                    end else begin
                        exp_word = q.pop_front();
                        chk($sformatf("sb_data_d%0d", D), 32'(ds_data_a[g]), 32'(exp_word));
                    end
                end
                if (us_valid && us_ready_a[g]) q.push_back(us_data);
                hold      = ds_valid_a[g] && !ds_ready;
                hold_data = ds_data_a[g];
            end
        end
    end

    initial begin
        int  acc;
        bit  fire;
        bit  seen;

        // ---------------- reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_us_ready", 32'(us_ready_a[1]), 32'd1);
        chk("rst_ds_valid", 32'(ds_valid_a[1]), 32'd0);
        chk("rst_ds_data",  32'(ds_data_a[1]),  32'd0);
`ifdef RV_PIPELINE_STATS_EN
        chk("rst_occupancy", 32'(g_dut[1].occupancy), 32'd0);
        chk("rst_xfer",      g_dut[1].xfer_count,      32'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- asynchronous reset pulse with a full pipe
        @(posedge clk); #1;
        us_valid = 1'b1; us_data = 16'h1234; ds_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("pulse_pre_full", 32'(us_ready_a[1]), 32'd0);
        #1 rst_n = 1'b0; us_valid = 1'b0;
        #1;
        chk("pulse_us_ready", 32'(us_ready_a[1]), 32'd1);
        chk("pulse_ds_valid", 32'(ds_valid_a[1]), 32'd0);
`ifdef RV_PIPELINE_STATS_EN
        chk("pulse_occupancy", 32'(g_dut[1].occupancy), 32'd0);
`endif
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;

        // ---------------- streaming 0..99
        ds_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            us_valid = 1'b1; us_data = 16'(i);
            @(negedge clk);
            chk("stream_us_ready", 32'(us_ready_a[1]), 32'd1);
            if (i >= 2) begin
                chk("stream_no_gap", 32'(ds_valid_a[1]), 32'd1);
                chk("stream_order",  32'(ds_data_a[1]),  32'(i - 2));
            end else begin
                chk("stream_latency", 32'(ds_valid_a[1]), 32'd0);
            end
        end
        @(posedge clk); #1 us_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stream_drained", 32'(ds_valid_a[1]), 32'd0);
        chk("stream_sb_empty", 32'(g_dut[1].q.size()), 32'd0);
`ifdef RV_PIPELINE_STATS_EN
        chk("stream_xfer", g_dut[1].xfer_count, 32'd100);
        chk("stream_occupancy", 32'(g_dut[1].occupancy), 32'd0);
`endif
        repeat (6) @(posedge clk);

        // ---------------- full backpressure
        #1 ds_ready = 1'b0; us_valid = 1'b1; us_data = 16'd0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            fire = us_ready_a[1];
            if (fire) acc++;
            @(posedge clk); #1;
            if (fire) us_data = us_data + 16'd1;
        end
        chk("bp_accepts", 32'(acc), 32'd4);
        @(negedge clk);
        chk("bp_us_ready_low", 32'(us_ready_a[1]), 32'd0);
        chk("bp_head_word",    32'(ds_data_a[1]),  32'd0);
`ifdef RV_PIPELINE_STATS_EN
        chk("bp_occupancy", 32'(g_dut[1].occupancy), 32'd4);
`endif
        @(posedge clk); #1 us_valid = 1'b0; ds_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = us_ready_a[1];
        end
        chk("bp_ready_return", 32'(seen), 32'd1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_sb_empty", 32'(g_dut[1].q.size()), 32'd0);

        // ---------------- random ready/valid
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            us_valid = (($urandom & 32'd3) != 0);
            ds_ready = (c < 1000) ? 1'($urandom) : ($urandom_range(0, 3) != 0);
            us_data  = 16'((c * 40503) ^ $urandom);
        end
        @(posedge clk); #1 us_valid = 1'b0; ds_ready = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("rand_empty_d1", 32'(g_dut[0].q.size()), 32'd0);
        chk("rand_empty_d2", 32'(g_dut[1].q.size()), 32'd0);
        chk("rand_empty_d5", 32'(g_dut[2].q.size()), 32'd0);

        // ---------------- reset flush
        @(posedge clk); #1 ds_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            us_valid = 1'b1; us_data = 16'(16'hA000 + k);
        end
        @(posedge clk); #1 us_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_valid", 32'(ds_valid_a[1]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("flush_ds_valid", 32'(ds_valid_a[1]), 32'd0);
`ifdef RV_PIPELINE_STATS_EN
        chk("flush_occupancy", 32'(g_dut[1].occupancy), 32'd0);
`endif
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1; us_valid = 1'b1; us_data = 16'hBEEF; ds_ready = 1'b1;
        @(posedge clk); #1 us_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = ds_valid_a[1];
        end
        chk("flush_first_seen", 32'(seen), 32'd1);
        chk("flush_first_word", 32'(ds_data_a[1]), 32'h0000BEEF);
        repeat (8) @(posedge clk);

`ifdef RV_PIPELINE_STATS_EN
        // ---------------- xfer_count wrap
        @(negedge clk);
        force g_dut[1].u_dut.r_xfer_count = 32'hFFFFFFFE;
        @(posedge clk); #1;
        release g_dut[1].u_dut.r_xfer_count;
        chk("wrap_forced", g_dut[1].xfer_count, 32'hFFFFFFFE);
        us_valid = 1'b1; us_data = 16'h0001;
        @(posedge clk); #1 us_data = 16'h0002;
        @(posedge clk); #1 us_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("wrap_xfer", g_dut[1].xfer_count, 32'h00000000);
`endif

        @(negedge clk);
        chk("final_empty_d1", 32'(g_dut[0].q.size()), 32'd0);
        chk("final_empty_d2", 32'(g_dut[1].q.size()), 32'd0);
        chk("final_empty_d5", 32'(g_dut[2].q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
